// File: rtl/program_memory_spi_pkg.sv
// Shared constants for the SPI program-memory fetch engine: state encoding,
// default flash parameters and the lengths of each transaction phase.
package program_memory_spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;

  localparam logic [7:0] READ_CMD_DEF   = 8'h3B;
  localparam int         DUMMY_CLKS_DEF = 8;

  localparam logic [4:0] CMD_BITS   = 5'd8;
  localparam logic [4:0] ADDR_BITS  = 5'd24;
  localparam logic [4:0] READ_PAIRS = 5'd8;

  // A burst continues the open read stream; wrapping past 0xFFFF is a jump.
  function automatic logic is_burst(input logic [15:0] cur, input logic [15:0] nxt);
    return (cur != 16'hFFFF) && (nxt == cur + 16'd1);
  endfunction

endpackage

// File: rtl/program_memory_spi.sv
// Fetches 16-bit instruction words from a SPI flash using Dual Output Fast
// Read, keeping the read open so sequential fetches stream without a new command.
module program_memory_spi
  import program_memory_spi_pkg::*;
#(
  parameter logic [7:0] READ_CMD   = READ_CMD_DEF,
  parameter int         DUMMY_CLKS = DUMMY_CLKS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  output logic [15:0] instruction,
  output logic        ready,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_io0_o,
  output logic        spi_io0_oe,
  input  logic        spi_io0_i,
  output logic        spi_io1_o,
  output logic        spi_io1_oe,
  input  logic        spi_io1_i
);

  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CLKS - 1);

  logic [2:0]  state, state_d;
  logic [4:0]  bit_cnt, bit_cnt_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        io0_q, io0_d;
  logic        oe_q, oe_d;
  logic [15:0] fetch_q, fetch_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] instr_q, instr_d;

  logic [23:0] byte_addr;
  logic [4:0]  cmd_idx;
  logic [4:0]  addr_idx;

  assign byte_addr = {7'b0, fetch_q, 1'b0};
  // Index of the bit to present after the bit_cnt-th rising edge.
  assign cmd_idx   = (CMD_BITS - 5'd1) - bit_cnt;
  assign addr_idx  = (ADDR_BITS - 5'd1) - bit_cnt;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    io0_d     = io0_q;
    oe_d      = oe_q;
    fetch_d   = fetch_q;
    rd_d      = rd_q;
    instr_d   = instr_q;
    case (state)
      ST_IDLE: begin
        fetch_d   = address;
        cs_d      = 1'b0;
        sclk_d    = 1'b0;
        io0_d     = READ_CMD[7];
        oe_d      = 1'b1;
        bit_cnt_d = 5'd0;
        state_d   = ST_CMD;
      end
      ST_CMD: begin
        if (!sclk_q) begin
          sclk_d    = 1'b1;
          bit_cnt_d = bit_cnt + 5'd1;
        end else begin
          sclk_d = 1'b0;
          if (bit_cnt == CMD_BITS) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 5'd0;
            io0_d     = byte_addr[23];
          end else begin
            io0_d = READ_CMD[cmd_idx[2:0]];
          end
        end
      end
      ST_ADDR: begin
        if (!sclk_q) begin
          sclk_d    = 1'b1;
          bit_cnt_d = bit_cnt + 5'd1;
        end else begin
          sclk_d = 1'b0;
          if (bit_cnt == ADDR_BITS) begin
            state_d   = ST_DUMMY;
            bit_cnt_d = 5'd0;
            io0_d     = 1'b0;
            oe_d      = 1'b0;
          end else begin
            io0_d = byte_addr[addr_idx];
          end
        end
      end
      ST_DUMMY: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
          if (bit_cnt == DUMMY_LAST) begin
            state_d   = ST_READ;
            bit_cnt_d = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end else begin
          sclk_d = 1'b0;
        end
      end
      ST_READ: begin
        if (sclk_q) begin
          sclk_d = 1'b0;
        end else begin
          sclk_d = 1'b1;
          rd_d   = {rd_q[13:0], spi_io1_i, spi_io0_i};
          if (bit_cnt == READ_PAIRS - 5'd1) begin
            instr_d   = rd_d;
            bit_cnt_d = 5'd0;
            state_d   = ST_WAIT;
          end else begin
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end
      end
      ST_WAIT: begin
        if (address == fetch_q) begin
          state_d = ST_WAIT;
        end else if (is_burst(fetch_q, address)) begin
          // SCLK is still high, so the next clk is the flash's shift edge.
          fetch_d   = address;
          state_d   = ST_READ;
          bit_cnt_d = 5'd0;
        end else begin
          cs_d    = 1'b1;
          sclk_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= 5'd0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      io0_q   <= 1'b0;
      oe_q    <= 1'b0;
      fetch_q <= 16'd0;
      rd_q    <= 16'd0;
      instr_q <= 16'd0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      io0_q   <= io0_d;
      oe_q    <= oe_d;
      fetch_q <= fetch_d;
      rd_q    <= rd_d;
      instr_q <= instr_d;
    end
  end

  assign ready       = (state == ST_WAIT) && (address == fetch_q);
  assign instruction = instr_q;
  assign spi_cs      = cs_q;
  assign spi_sclk    = sclk_q;
  assign spi_io0_o   = io0_q;
  assign spi_io0_oe  = oe_q;
  assign spi_io1_o   = 1'b0;
  assign spi_io1_oe  = 1'b0;

endmodule

// File: tb/tb_program_memory_spi.sv
// Directed bench for program_memory_spi with a behavioural dual-output flash.
module tb_program_memory_spi;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [15:0] instruction;
  logic        ready;
  logic        spi_cs, spi_sclk;
  logic        spi_io0_o, spi_io0_oe, spi_io1_o, spi_io1_oe;
  logic        spi_io0_i = 1'b0;
  logic        spi_io1_i = 1'b0;

  program_memory_spi dut (
    .clk(clk), .rst(rst), .address(address), .instruction(instruction),
    .ready(ready), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_io0_o(spi_io0_o), .spi_io0_oe(spi_io0_oe), .spi_io0_i(spi_io0_i),
    .spi_io1_o(spi_io1_o), .spi_io1_oe(spi_io1_oe), .spi_io1_i(spi_io1_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Flash contents: a few fixed words, everything else a simple pattern.
  function automatic logic [15:0] flash_word(input logic [15:0] a);
    case (a)
      16'h1234: return 16'hABCD;
      16'h1235: return 16'h5566;
      16'h9000: return 16'hDEAD;
      default:  return a ^ 16'h5A3C;
    endcase
  endfunction

  int          rc = 0;
  int          p  = 0;
  logic [7:0]  cmd_cap  = '0;
  logic [23:0] addr_cap = '0;
  int          cs_rises = 0;
  int          cs_falls = 0;
  int          oe_viol  = 0;

  always @(posedge spi_cs) cs_rises++;
  always @(negedge spi_cs) begin
    cs_falls++;
    rc = 0; p = 0; cmd_cap = '0; addr_cap = '0;
  end

  always @(posedge spi_sclk) begin
    if (spi_cs === 1'b0) begin
      if (rc < 8)       cmd_cap  = {cmd_cap[6:0], spi_io0_o};
      else if (rc < 32) addr_cap = {addr_cap[22:0], spi_io0_o};
      rc++;
    end
  end

  always @(negedge spi_sclk) begin
    logic [15:0] w;
    int k;
    if (spi_cs === 1'b0 && rc >= 40) begin
      w = flash_word(addr_cap[16:1] + 16'(p / 8));
      k = p % 8;
      spi_io1_i = w[15 - 2*k];
      spi_io0_i = w[14 - 2*k];
      p++;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && dut.state >= 3'd3 && (spi_io0_oe !== 1'b0 || spi_io1_oe !== 1'b0))
      oe_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int maxc, input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    int r0, f0, n;

    // Reset state
    rst = 1'b1;
    address = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_state",    {29'b0, dut.state}, 32'd0);
    chk("rst_bit_cnt",  {27'b0, dut.bit_cnt}, 32'd0);
    chk("rst_cs",       {31'b0, spi_cs}, 32'd1);
    chk("rst_sclk",     {31'b0, spi_sclk}, 32'd0);
    chk("rst_oe",       {30'b0, spi_io0_oe, spi_io1_oe}, 32'd0);
    chk("rst_io",       {30'b0, spi_io0_o, spi_io1_o}, 32'd0);
    chk("rst_instr",    {16'b0, instruction}, 32'd0);
    chk("rst_ready",    {31'b0, ready}, 32'd0);

    // First fetch starts on the clk after release
    rst = 1'b0;
    @(negedge clk);
    chk("start_cs", {31'b0, spi_cs}, 32'd0);
    chk("start_state", {29'b0, dut.state}, 32'd1);
    wait_ready(100, "first_ready");
    chk("first_cmd",   {24'b0, cmd_cap}, 32'h3B);
    chk("first_addr",  {8'b0, addr_cap}, 32'h002468);
    chk("first_instr", {16'b0, instruction}, 32'hABCD);
    chk("first_state", {29'b0, dut.state}, 32'd5);
    repeat (5) @(negedge clk);
    chk("hold_ready",  {31'b0, ready}, 32'd1);
    chk("hold_cs",     {31'b0, spi_cs}, 32'd0);

    // Sequential burst
    r0 = cs_rises; f0 = cs_falls;
    address = 16'h1235;
    #1;
    chk("burst_ready_fall", {31'b0, ready}, 32'd0);
    @(negedge clk);
    chk("burst_state", {29'b0, dut.state}, 32'd4);
    wait_ready(20, "burst_ready");
    chk("burst_instr", {16'b0, instruction}, 32'h5566);
    chk("burst_no_cs", cs_rises + cs_falls, r0 + f0);
    chk("burst_cs_low", {31'b0, spi_cs}, 32'd0);

    // Jump
    r0 = cs_rises;
    address = 16'h9000;
    @(negedge clk);
    chk("jump_cs_high", {31'b0, spi_cs}, 32'd1);
    chk("jump_sclk", {31'b0, spi_sclk}, 32'd0);
    wait_ready(120, "jump_ready");
    chk("jump_pulse", cs_rises, r0 + 1);
    chk("jump_cmd",   {24'b0, cmd_cap}, 32'h3B);
    chk("jump_addr",  {8'b0, addr_cap}, 32'h012000);
    chk("jump_instr", {16'b0, instruction}, 32'hDEAD);

    // 0xFFFF followed by 0x0000 is a jump, not a burst
    address = 16'hFFFF;
    @(negedge clk);
    wait_ready(120, "ffff_ready");
    chk("ffff_instr", {16'b0, instruction}, 32'hA5C3);
    r0 = cs_rises;
    address = 16'h0000;
    @(negedge clk);
    chk("wrap_state", {29'b0, dut.state}, 32'd0);
    wait_ready(120, "wrap_ready");
    chk("wrap_pulse", cs_rises, r0 + 1);
    chk("wrap_addr",  {8'b0, addr_cap}, 32'h000000);
    chk("wrap_instr", {16'b0, instruction}, 32'h5A3C);

    // Reset in the middle of the address phase
    address = 16'h4321;
    n = 0;
    while (dut.state !== 3'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr", {29'b0, dut.state}, 32'd2);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_cs",    {31'b0, spi_cs}, 32'd1);
    chk("abort_sclk",  {31'b0, spi_sclk}, 32'd0);
    chk("abort_ready", {31'b0, ready}, 32'd0);
    chk("abort_instr", {16'b0, instruction}, 32'd0);
    chk("abort_state", {29'b0, dut.state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(100, "refetch_ready");
    chk("refetch_addr",  {8'b0, addr_cap}, 32'h008642);
    chk("refetch_instr", {16'b0, instruction}, 32'h191D);

    chk("oe_while_flash", oe_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
